// File: rtl/result_fifo.sv
// result_fifo: ordered result-word buffer between the engine datapath and its consumer.
// Optional RESULT_FIFO_ALMOST_FULL_EN adds a registered almost_full output.
module result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
`ifdef RESULT_FIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Acceptance: a read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    always_comb begin
        rd_ok      = rd_req & ~empty;
        wr_ok      = wr_req & (~full | rd_ok);
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and explicit occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Registered read port; rd_data holds its value between pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    // Sticky misuse flags; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr_err) | (wr_req & ~wr_ok);
            underflow <= (underflow & ~clr_err) | (rd_req & empty);
        end
    end

`ifdef RESULT_FIFO_ALMOST_FULL_EN
    // Raised once fewer than four entries remain, i.e. a whole batch no longer fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next > (ADDR_W+1)'(DEPTH - 4));
        end
    end
`endif

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: scoreboard bench for result_fifo.
// Expected words are queued when a write is accepted and compared as rd_valid appears.
module tb_result_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;
`ifdef RESULT_FIFO_ALMOST_FULL_EN
    logic              almost_full;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb_q[$];
    int                m_cnt;
    logic              m_ovf;
    logic              m_unf;
    logic [DATA_W-1:0] m_last;

    result_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .full     (full),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow),
        .clr_err  (clr_err)
`ifdef RESULT_FIFO_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_last = '0;
    endtask

    task automatic check_status();
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef RESULT_FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(m_cnt > DEPTH - 4));
`endif
    endtask

    // One clock: drive at edge+1, predict, then sample at next edge+1.
    task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        logic rok;
        logic wok;
        wr_req  = w;
        wr_data = d;
        rd_req  = r;
        clr_err = c;
        rok = r && (m_cnt > 0);
        wok = w && ((m_cnt < DEPTH) || rok);
        if (wok) sb_q.push_back(d);
        @(posedge clk);
        #1;
        m_cnt = m_cnt + (wok ? 1 : 0) - (rok ? 1 : 0);
        m_ovf = (m_ovf & ~c) | (w & ~wok);
        m_unf = (m_unf & ~c) | (r & ~rok);
        chk("rd_valid", 32'(rd_valid), 32'(rok));
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underrun", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                m_last = sb_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(m_last));
            end
        end else begin
            chk("rd_hold", 32'(rd_data), 32'(m_last));
        end
        check_status();
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr_req  = 1'b0;
        wr_data = '0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_status();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Four-word batch, then drain.
        cyc(1'b1, 16'h0011, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 1'b0, 1'b0);
        cyc(1'b1, 16'h0033, 1'b0, 1'b0);
        cyc(1'b1, 16'h0044, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Fill, overflow, drain, clear.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Write and read together while full, then drain.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'h0200, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Write and read together while empty: no fall-through.
        cyc(1'b1, 16'h0555, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Clear and a new error in the same cycle: the error wins.
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Mixed random traffic.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0));
        end
        while (m_cnt > 0) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset at count 6 with a read in flight.
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0700 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'h0706, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 16'h0808, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
